// File: rtl/barrett_ctrl_pkg.sv
// Shared types and helpers for the barrett reducer arbiter.
// Geometry, modulus context, issue tag and round-robin pick.
package barrett_ctrl_pkg;

  localparam int LOGQ    = 32;
  localparam int LOGQH   = 15;
  localparam int N_REQ   = 4;
  localparam int IDW     = $clog2(N_REQ);
  localparam int LOGLOGQ = $clog2(LOGQ + 1);
  localparam int CW      = 2 * LOGQ;

  typedef struct packed {
    logic [LOGLOGQ-1:0] B;
    logic [LOGQ:0]      MU;
    logic [LOGQH-1:0]   qH;
  } barrett_ctx_t;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } barrett_tag_t;

  function automatic int barrett_lat(input bit correct);
    return correct ? 3 : 2;
  endfunction

  function automatic logic [LOGQ-1:0] q_of(
    input logic [LOGQH-1:0] qh
  );
    return {qh, {(LOGQ-LOGQH-1){1'b0}}, 1'b1};
  endfunction

  // {found, index}: first set bit at or after ptr, wrapping
  function automatic logic [IDW:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [IDW-1:0]   ptr
  );
    logic [IDW:0] r;
    int           j;
    r = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N_REQ;
      if (req[j]) r = {1'b1, IDW'(j)};
    end
    return r;
  endfunction

endpackage

// File: rtl/barrett_arbiter_if.sv
// Requester, config and result bundle of the shared reducer.
// slave = arbiter side, master = lanes / consumer side.
interface barrett_arbiter_if;
  import barrett_ctrl_pkg::*;

  logic                 cfg_we;
  logic [IDW-1:0]       cfg_id;
  logic [LOGLOGQ-1:0]   cfg_B;
  logic [LOGQ:0]        cfg_MU;
  logic [LOGQH-1:0]     cfg_qH;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*CW-1:0]  req_C;
  logic                 res_valid;
  logic                 res_ready;
  logic [LOGQ-1:0]      res_T;
  logic [IDW-1:0]       res_id;

  modport slave (
    input  cfg_we, cfg_id, cfg_B, cfg_MU, cfg_qH,
    input  req_valid, req_C, res_ready,
    output req_ready, res_valid, res_T, res_id
  );

  modport master (
    output cfg_we, cfg_id, cfg_B, cfg_MU, cfg_qH,
    output req_valid, req_C, res_ready,
    input  req_ready, res_valid, res_T, res_id
  );

endinterface

// File: rtl/barrett_reduce.sv
// Pipelined barrett reduction C mod q, q carried along the pipe.
// Datapath only, no reset; validity is tracked by the caller.
module barrett_reduce
  import barrett_ctrl_pkg::*;
#(
  parameter bit CORRECT = 1'b1
) (
  input  logic            clk,
  input  logic [CW-1:0]   c,
  input  barrett_ctx_t    ctx,
  output logic [LOGQ-1:0] t
);

  localparam int RW = LOGQ + 2;
  localparam int PW = CW + 8;

  logic [LOGLOGQ-1:0] sh_lo;
  logic [LOGLOGQ-1:0] sh_hi;
  logic [PW-1:0]      prod;
  logic [RW-1:0]      c_a;
  logic [RW-1:0]      q3_a;
  logic [RW-1:0]      r_b;
  logic [LOGQ-1:0]    q_a;
  logic [LOGQ-1:0]    q_b;

  assign sh_lo = ctx.B - LOGLOGQ'(1);
  assign sh_hi = ctx.B + LOGLOGQ'(1);
  assign prod  = PW'(c >> sh_lo) * PW'(ctx.MU);

  // r < 3q, so the low RW bits of C - q3*q are exact
  always_ff @(posedge clk) begin
    c_a  <= RW'(c);
    q3_a <= RW'(prod >> sh_hi);
    q_a  <= q_of(ctx.qH);
    r_b  <= c_a - q3_a * RW'(q_a);
    q_b  <= q_a;
  end

  if (CORRECT) begin : g_corr
    logic [RW-1:0]   qe;
    logic [RW-1:0]   r1;
    logic [RW-1:0]   r2;
    logic [LOGQ-1:0] t_c;
    assign qe = RW'(q_b);
    assign r1 = (r_b >= qe) ? r_b - qe : r_b;
    assign r2 = (r1 >= qe) ? r1 - qe : r1;
    always_ff @(posedge clk) t_c <= LOGQ'(r2);
    assign t = t_c;
  end else begin : g_raw
    assign t = LOGQ'(r_b);
  end

endmodule

// File: rtl/barrett_res_fifo.sv
// Synchronous result FIFO; head is read straight from storage.
// Occupancy is exported so the owner derives valid from it.
module barrett_res_fifo #(
  parameter int DEP = 8,
  parameter int W   = 34
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEP+1)-1:0] count
);

  localparam int AW = (DEP > 1) ? $clog2(DEP) : 1;

  logic [W-1:0]  mem [DEP];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEP - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/barrett_arbiter.sv
// Round-robin sharing of one barrett reducer between requesters,
// results returned in issue order through a credit-guarded FIFO.
module barrett_arbiter
  import barrett_ctrl_pkg::*;
#(
  parameter int FIFO_DEP = 8
) (
  input  logic             clk,
  input  logic             rst,
  barrett_arbiter_if.slave bus
);

  localparam int LAT = barrett_lat(1'b1);
  localparam int CRW = $clog2(FIFO_DEP + 1);
  localparam int FW  = LOGQ + IDW;

  barrett_ctx_t     ctx [N_REQ];
  barrett_ctx_t     ctx_sel;
  barrett_tag_t     tag [LAT];
  logic [N_REQ-1:0] ctx_vld;
  logic [N_REQ-1:0] elig;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gid;
  logic [IDW:0]     pick;
  logic             gnt;
  logic             pop;
  logic [CRW-1:0]   credit;
  logic [CRW-1:0]   fifo_cnt;
  logic [CW-1:0]    c_sel;
  logic [LOGQ-1:0]  red_t;
  logic [FW-1:0]    fifo_out;

  assign elig = (rst || credit == '0) ? '0
              : bus.req_valid & ctx_vld;
  assign pick = rr_pick(elig, rr_ptr);
  assign gnt  = pick[IDW];
  assign gid  = pick[IDW-1:0];
  assign pop  = bus.res_valid && bus.res_ready;

  assign bus.req_ready = gnt ? (N_REQ'(1) << gid) : '0;

  // ctx is a register, so a same-cycle write is seen next issue
  assign c_sel   = bus.req_C[gid*CW +: CW];
  assign ctx_sel = ctx[gid];

  always_ff @(posedge clk) begin
    if (bus.cfg_we)
      ctx[bus.cfg_id] <= {bus.cfg_B, bus.cfg_MU, bus.cfg_qH};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctx_vld <= '0;
      rr_ptr  <= '0;
      credit  <= CRW'(FIFO_DEP);
    end else begin
      if (bus.cfg_we) ctx_vld[bus.cfg_id] <= 1'b1;
      if (gnt)
        rr_ptr <= (gid == IDW'(N_REQ - 1)) ? '0 : gid + 1'b1;
      if (gnt && !pop)      credit <= credit - 1'b1;
      else if (!gnt && pop) credit <= credit + 1'b1;
    end
  end

  // stale reducer data is dropped because these valids clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) tag[i] <= '0;
    end else begin
      tag[0] <= '{vld: gnt, id: gid};
      for (int i = 1; i < LAT; i++) tag[i] <= tag[i-1];
    end
  end

  barrett_reduce #(
    .CORRECT (1'b1)
  ) u_red (
    .clk (clk),
    .c   (c_sel),
    .ctx (ctx_sel),
    .t   (red_t)
  );

  barrett_res_fifo #(
    .DEP (FIFO_DEP),
    .W   (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag[LAT-1].vld),
    .din   ({red_t, tag[LAT-1].id}),
    .pop   (pop),
    .dout  (fifo_out),
    .count (fifo_cnt)
  );

  assign bus.res_valid = (fifo_cnt != '0);
  assign {bus.res_T, bus.res_id} = fifo_out;

endmodule

// File: tb/tb_barrett_arbiter.sv
// Scoreboard bench for barrett_arbiter: issue-time expectations,
// checked when results leave the FIFO.
module tb_barrett_arbiter;
  import barrett_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   issue_cnt = 0;

  logic [LOGQ+IDW-1:0] sb [$];
  longint unsigned     m_q [N_REQ];

  barrett_arbiter_if bus ();

  barrett_arbiter #(
    .FIFO_DEP (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint unsigned qv(input int qh);
    return (longint'(qh) << 17) | 64'd1;
  endfunction

  function automatic longint unsigned rnd_c(input int qh);
    longint unsigned q;
    q = qv(qh);
    return {$urandom(), $urandom()} % (q * q);
  endfunction

  always @(posedge clk)
    if (bus.cfg_we) m_q[bus.cfg_id] <= qv(int'(bus.cfg_qH));

  // scoreboard: push at issue, compare at pop
  always @(negedge clk) begin
    longint unsigned c;
    logic [LOGQ+IDW-1:0] e;
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          c = bus.req_C[i*CW +: CW];
          sb.push_back({LOGQ'(c % m_q[i]), IDW'(i)});
          issue_cnt++;
        end
      if (bus.res_valid && bus.res_ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result got T=%0d id=%0d",
                   bus.res_T, bus.res_id);
        end else begin
          e = sb.pop_front();
          if ({bus.res_T, bus.res_id} !== e) begin
            n_err++;
            $display("FAIL result got T=%0d id=%0d want T=%0d id=%0d",
                     bus.res_T, bus.res_id,
                     e[LOGQ+IDW-1:IDW], e[IDW-1:0]);
          end
        end
      end
      if (dut.fifo_cnt > 8) begin
        n_err++;
        $display("FAIL fifo_overflow got %0d want <=8", dut.fifo_cnt);
      end
    end
  end

  task automatic set_cfg(input int id, input int qh);
    longint unsigned q;
    int b;
    q = qv(qh);
    b = $clog2(q + 1);
    bus.cfg_we = 1'b1;
    bus.cfg_id = IDW'(id);
    bus.cfg_B  = LOGLOGQ'(b);
    bus.cfg_MU = (LOGQ+1)'((64'd1 << (2 * b)) / q);
    bus.cfg_qH = LOGQH'(qh);
  endtask

  task automatic cfg(input int id, input int qh);
    @(posedge clk); #1;
    set_cfg(id, qh);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.res_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req_valid = 4'hf;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.res_valid !== 1'b0 || bus.req_ready !== 4'h0) begin
      n_err++;
      $display("FAIL reset_out got v=%b rdy=%b want 0 0",
               bus.res_valid, bus.req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.req_ready !== 4'h0) begin
      n_err++;
      $display("FAIL unconfigured_rdy got %b want 0000", bus.req_ready);
    end
    n_vec++;
    if (dut.credit !== 4'd8 || dut.rr_ptr !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state got credit=%0d ptr=%0d want 8 0",
               dut.credit, dut.rr_ptr);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
  endtask

  task automatic test_basic;
    longint unsigned cs [3];
    int ex [3];
    int t0;
    bit got;
    cs = '{64'd0, 64'd131073, 64'd131072 * 64'd131072};
    ex = '{0, 0, 1};
    do_reset();
    cfg(0, 1);
    bus.res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus.req_C[0 +: CW] = cs[k];
      bus.req_valid = 4'b0001;
      got = 1'b0;
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        if (bus.req_ready[0]) begin got = 1'b1; break; end
      end
      t0 = cyc;
      @(posedge clk); #1;
      bus.req_valid = '0;
      n_vec++;
      if (!got) begin
        n_err++;
        $display("FAIL basic_grant got none want grant k=%0d", k);
        continue;
      end
      got = 1'b0;
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        if (bus.res_valid) begin got = 1'b1; break; end
      end
      n_vec++;
      if (!got || cyc - t0 != barrett_lat(1'b1) + 1) begin
        n_err++;
        $display("FAIL basic_latency got %0d want %0d",
                 cyc - t0, barrett_lat(1'b1) + 1);
      end
      n_vec++;
      if (bus.res_T !== LOGQ'(ex[k]) || bus.res_id !== 2'd0) begin
        n_err++;
        $display("FAIL basic_T got T=%0d id=%0d want T=%0d id=0",
                 bus.res_T, bus.res_id, ex[k]);
      end
    end
  endtask

  task automatic test_rr;
    int qs [4];
    int g;
    bit ok;
    qs = '{1, 2, 3, 5};
    do_reset();
    for (int i = 0; i < 4; i++) cfg(i, qs[i]);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) bus.req_C[i*CW +: CW] = rnd_c(qs[i]);
    bus.req_valid = 4'hf;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      g = k % 4;
      n_vec++;
      if (bus.req_ready !== 4'(1 << g)) begin
        n_err++;
        $display("FAIL rr_grant k=%0d got %b want %b",
                 k, bus.req_ready, 4'(1 << g));
      end
      @(posedge clk); #1;
      bus.req_C[g*CW +: CW] = rnd_c(qs[g]);
    end
    bus.req_valid = '0;
    wait_drain(ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL rr_drain got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_backpressure;
    int s;
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) cfg(i, i + 1);
    bus.res_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) bus.req_C[i*CW +: CW] = rnd_c(i + 1);
    s = issue_cnt;
    bus.req_valid = 4'hf;
    repeat (20) @(negedge clk);
    n_vec++;
    if (issue_cnt - s != 8 || bus.req_ready !== 4'h0) begin
      n_err++;
      $display("FAIL bp_issues got %0d rdy=%b want 8 0000",
               issue_cnt - s, bus.req_ready);
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    s = issue_cnt;
    repeat (10) @(negedge clk);
    n_vec++;
    if (issue_cnt - s != 1) begin
      n_err++;
      $display("FAIL bp_one_pop got %0d want 1", issue_cnt - s);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    wait_drain(ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL bp_drain got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_unconfigured;
    int seq [3];
    bit ok;
    seq = '{0, 2, 3};
    do_reset();
    cfg(0, 7);
    cfg(2, 9);
    cfg(3, 11);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) bus.req_C[i*CW +: CW] = rnd_c(7);
    bus.req_valid = 4'hf;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_vec++;
      if (bus.req_ready !== 4'(1 << seq[k % 3])) begin
        n_err++;
        $display("FAIL skip_grant k=%0d got %b want %b",
                 k, bus.req_ready, 4'(1 << seq[k % 3]));
      end
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_drain(ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL skip_drain got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_cfg_rbw;
    int got [2];
    int n_got;
    do_reset();
    cfg(2, 1);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    set_cfg(2, 3);
    bus.req_C[2*CW +: CW] = 64'd1000000;
    bus.req_valid = 4'b0100;
    @(negedge clk);
    n_vec++;
    if (bus.req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL rbw_grant0 got %b want 0100", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL rbw_grant1 got %b want 0100", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    n_got = 0;
    for (int n = 0; n < 20 && n_got < 2; n++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        got[n_got] = int'(bus.res_T);
        n_got++;
      end
    end
    n_vec++;
    if (n_got != 2 || got[0] != 82489 || got[1] != 213566) begin
      n_err++;
      $display("FAIL rbw_T got n=%0d %0d %0d want 82489 213566",
               n_got, got[0], got[1]);
    end
  endtask

  task automatic test_reset_mid;
    int s;
    bit stale;
    do_reset();
    for (int i = 0; i < 4; i++) cfg(i, i + 2);
    bus.res_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) bus.req_C[i*CW +: CW] = rnd_c(i + 2);
    s = issue_cnt;
    bus.req_valid = 4'hf;
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    bus.req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (issue_cnt - s != 5 || bus.res_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_setup got issues=%0d v=%b want 5 1",
               issue_cnt - s, bus.res_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    bus.res_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.res_valid !== 1'b0 || dut.credit !== 4'd8) begin
      n_err++;
      $display("FAIL mid_reset got v=%b credit=%0d want 0 8",
               bus.res_valid, dut.credit);
    end
    stale = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.res_valid) stale = 1'b1;
    end
    n_vec++;
    if (stale) begin
      n_err++;
      $display("FAIL mid_stale got res_valid=1 want 0");
    end
  endtask

  initial begin
    bus.cfg_we    = 1'b0;
    bus.cfg_id    = '0;
    bus.cfg_B     = '0;
    bus.cfg_MU    = '0;
    bus.cfg_qH    = '0;
    bus.req_valid = '0;
    bus.req_C     = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_rr();
    test_backpressure();
    test_unconfigured();
    test_cfg_rbw();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
